entrada_bcd_binario: RTL and testbench
======================================

# entrada_bcd_binario

Sequential operand-entry block for the adder/subtractor board design. It converts the decimal direction back to binary: two BCD digits (tens, then units) are keyed in one at a time from switches with a pushbutton. An optional sign is applied, and the block outputs a validated 6-bit two's-complement operand ready to feed the 6-bit adder chain.

## Interface
- DEBOUNCE_CICLOS, 16, number of consecutive stable cycles required before a button level change is accepted. Used only with DEBOUNCE_EN. Use 16 for simulation; board builds use 1000000.

- CLOCK_50  in  1  system clock, rising-edge active
- RESET_N  in  1  asynchronous, active-low reset
- DIGITO  in  4  BCD digit from switches, sampled at capture
- SINAL  in  1  1 = negative operand, sampled at units capture
- CARREGA_N  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50
- LIMPA  in  1  synchronous clear, active-high
- VALOR  out  6  two's-complement operand
- VALIDO  out  1  high while VALOR holds a completed, in-range entry
- ERRO  out  1  high while the last entry is invalid
- DEZENA  out  4  captured tens digit, for display echo
- UNIDADE  out  4  captured units digit, for display echo

## Operation
- Button path:
  - 3-flop chain sync1, sync2, prev, all resetting to 1 (released).
  - Press pulse = prev & ~sync2. Exactly one pulse per press; release generates nothing.
- FSM states: ESPERA_DEZENA (reset state), ESPERA_UNIDADE, CALCULA, PRONTO, FALHA.
  - ESPERA_DEZENA + pulse:
    - Capture DIGITO into DEZENA.
    - Clear UNIDADE, VALIDO and ERRO.
    - If DIGITO > 9, go to FALHA; otherwise go to ESPERA_UNIDADE.
  - ESPERA_UNIDADE + pulse:
    - Capture DIGITO into UNIDADE and SINAL into an internal sign register.
    - If DIGITO > 9, go to FALHA; otherwise go to CALCULA.
  - CALCULA (one cycle, unconditional):
    - mag[6:0] = DEZENA*10 + UNIDADE, computed as (DEZENA<<3) + (DEZENA<<1) + UNIDADE.
    - If mag > 31, go to FALHA.
    - Otherwise VALOR = sign ? (~mag[5:0] + 1) : mag[5:0], VALIDO = 1, and go to PRONTO.
  - PRONTO and FALHA + pulse: same behaviour as ESPERA_DEZENA + pulse (a new entry starts immediately).
  - In FALHA, ERRO = 1, VALIDO = 0 and VALOR keeps its previous value.
- Magnitude 0 with the sign set yields VALOR = 0. Valid range is -31..+31.
- LIMPA: next edge returns to ESPERA_DEZENA and zeroes VALOR, VALIDO, ERRO, DEZENA and UNIDADE. LIMPA has priority over a simultaneous pulse, and that pulse is discarded.
- DIGITO and SINAL are ignored outside their capture edges.

## Timing
- Reset values: VALOR=0, VALIDO=0, ERRO=0, DEZENA=0, UNIDADE=0, state=ESPERA_DEZENA, sync/prev=1, debounce counter=0.
- Reset is asynchronous and takes effect mid-entry with no residue. After RESET_N deasserts, a button that is still held produces no pulse until it is released and pressed again.
- Without DEBOUNCE_EN, edge 1 is the first rising edge that samples CARREGA_N low. Sequence:
  - Edge 1: sync1 goes low.
  - Edge 2: sync2 goes low and the pulse is high for one cycle.
  - Edge 3: the FSM captures the digit.
- After a units capture at edge N, the FSM is in CALCULA during cycle N→N+1. VALIDO/ERRO and VALOR update at edge N+1.
- FALHA from a digit > 9 is entered at the capture edge itself.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- DEBOUNCE_EN defined:
  - A counter (width $clog2(DEBOUNCE_CICLOS+1)) sits between sync2 and prev.
  - The debounced level takes sync2 only after sync2 has differed from it for DEBOUNCE_CICLOS consecutive cycles. Any bounce restarts the count.
  - Capture latency = 2 + DEBOUNCE_CICLOS + 1 edges.
- DEBOUNCE_EN undefined: no counter and no DEBOUNCE_CICLOS logic; latency is 3 edges as specified under Timing.

## Test plan
- Reset, press with DIGITO=2, press with DIGITO=3 and SINAL=0 → VALOR=6'b010111 (23), VALIDO=1 at edge N+1, ERRO=0, DEZENA=2, UNIDADE=3.
- Enter 1 then 5 with SINAL=1 → VALOR=6'b110001 (-15), VALIDO=1. A third press with DIGITO=0 → VALIDO=0 and DEZENA=0, state ESPERA_UNIDADE.
- Enter 4 then 0 → mag=40, ERRO=1, VALIDO=0, VALOR unchanged from the prior value. Enter 0,0 with SINAL=1 → VALOR=0, VALIDO=1.
- Press with DIGITO=12 → ERRO=1 at the capture edge, state FALHA. Next press with DIGITO=3 → ERRO=0, state ESPERA_UNIDADE.
- LIMPA in the same cycle as a press pulse → all outputs 0, state ESPERA_DEZENA, digit not captured. RESET_N low while in ESPERA_UNIDADE → reset values immediately; a held button yields no pulse after release of reset.
- With DEBOUNCE_EN and DEBOUNCE_CICLOS=16:
  - A 10-cycle low glitch on CARREGA_N → no capture.
  - A 20-cycle stable low → exactly one capture, 19 edges after the first low sample.
  - Bouncy release → no extra capture.

Source files
------------

// File: rtl/entrada_bcd_binario.sv
// Two-digit BCD operand entry (tens, then units) with optional sign, producing a 6-bit
// two's-complement operand. Define DEBOUNCE_EN to insert a pushbutton debounce counter.
module entrada_bcd_binario #(
  parameter int unsigned DEBOUNCE_CICLOS = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] DIGITO,
  input  logic       SINAL,
  input  logic       CARREGA_N,
  input  logic       LIMPA,
  output logic [5:0] VALOR,
  output logic       VALIDO,
  output logic       ERRO,
  output logic [3:0] DEZENA,
  output logic [3:0] UNIDADE
);

  if (DEBOUNCE_CICLOS < 1) begin : g_param_check
    $error("DEBOUNCE_CICLOS must be at least 1");
  end

  typedef enum logic [2:0] {
    EsperaDezena,
    EsperaUnidade,
    Calcula,
    Pronto,
    Falha
  } estado_t;

  logic       r_sync1, r_sync2, r_prev;
  logic [1:0] r_cheio;
  logic       r_armado;
  logic       w_nivel;
  logic       w_pulso;

  // r_cheio marks when sync2 holds a real post-reset sample; the button only arms once it
  // has been seen released, so a press held through reset is not taken as a new press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_prev   <= 1'b1;
      r_cheio  <= 2'b00;
      r_armado <= 1'b0;
    end else begin
      r_sync1  <= CARREGA_N;
      r_sync2  <= r_sync1;
      r_prev   <= w_nivel;
      r_cheio  <= {r_cheio[0], 1'b1};
      r_armado <= r_armado | (r_cheio[1] & r_sync2);
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CICLOS + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_deb;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
      r_deb <= 1'b1;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == CntW'(DEBOUNCE_CICLOS - 1)) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_nivel = r_deb;
`else
  assign w_nivel = r_sync2;
`endif

  assign w_pulso = r_armado & r_prev & ~w_nivel;

  estado_t    r_estado, w_estado_d;
  logic [3:0] r_dezena, w_dezena_d;
  logic [3:0] r_unidade, w_unidade_d;
  logic       r_sinal, w_sinal_d;
  logic [5:0] r_valor, w_valor_d;
  logic       r_valido, w_valido_d;
  logic       r_erro, w_erro_d;
  logic [6:0] w_mag;

  // tens*10 as shift-and-add
  assign w_mag = {r_dezena, 3'b000} + {2'b00, r_dezena, 1'b0} + {3'b000, r_unidade};

  always_comb begin
    w_estado_d  = r_estado;
    w_dezena_d  = r_dezena;
    w_unidade_d = r_unidade;
    w_sinal_d   = r_sinal;
    w_valor_d   = r_valor;
    w_valido_d  = r_valido;
    w_erro_d    = r_erro;

    if (LIMPA) begin
      w_estado_d  = EsperaDezena;
      w_dezena_d  = 4'd0;
      w_unidade_d = 4'd0;
      w_valor_d   = 6'd0;
      w_valido_d  = 1'b0;
      w_erro_d    = 1'b0;
    end else begin
      unique case (r_estado)
        EsperaDezena, Pronto, Falha: begin
          if (w_pulso) begin
            w_dezena_d  = DIGITO;
            w_unidade_d = 4'd0;
            w_valido_d  = 1'b0;
            if (DIGITO > 4'd9) begin
              w_erro_d   = 1'b1;
              w_estado_d = Falha;
            end else begin
              w_erro_d   = 1'b0;
              w_estado_d = EsperaUnidade;
            end
          end
        end
        EsperaUnidade: begin
          if (w_pulso) begin
            w_unidade_d = DIGITO;
            w_sinal_d   = SINAL;
            if (DIGITO > 4'd9) begin
              w_erro_d   = 1'b1;
              w_estado_d = Falha;
            end else begin
              w_estado_d = Calcula;
            end
          end
        end
        Calcula: begin
          if (w_mag > 7'd31) begin
            w_erro_d   = 1'b1;
            w_valido_d = 1'b0;
            w_estado_d = Falha;
          end else begin
            w_valor_d  = r_sinal ? (~w_mag[5:0] + 6'd1) : w_mag[5:0];
            w_valido_d = 1'b1;
            w_estado_d = Pronto;
          end
        end
        default: w_estado_d = EsperaDezena;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_estado  <= EsperaDezena;
      r_dezena  <= 4'd0;
      r_unidade <= 4'd0;
      r_sinal   <= 1'b0;
      r_valor   <= 6'd0;
      r_valido  <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_estado  <= w_estado_d;
      r_dezena  <= w_dezena_d;
      r_unidade <= w_unidade_d;
      r_sinal   <= w_sinal_d;
      r_valor   <= w_valor_d;
      r_valido  <= w_valido_d;
      r_erro    <= w_erro_d;
    end
  end

  assign VALOR   = r_valor;
  assign VALIDO  = r_valido;
  assign ERRO    = r_erro;
  assign DEZENA  = r_dezena;
  assign UNIDADE = r_unidade;

endmodule

// File: tb/tb_entrada_bcd_binario.sv
// Bench for entrada_bcd_binario: directed literal checks plus a per-cycle behavioural model
// under random button/digit/clear stimulus (model checking only in the default build).
module tb_entrada_bcd_binario;

  localparam int unsigned D = 16;
`ifdef DEBOUNCE_EN
  localparam int CAP  = 3 + D;
  localparam int HOLD = D + 6;
`else
  localparam int CAP  = 3;
  localparam int HOLD = 4;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [3:0] DIGITO;
  logic       SINAL;
  logic       CARREGA_N;
  logic       LIMPA;
  logic [5:0] VALOR;
  logic       VALIDO;
  logic       ERRO;
  logic [3:0] DEZENA;
  logic [3:0] UNIDADE;

  entrada_bcd_binario #(.DEBOUNCE_CICLOS(D)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .DIGITO   (DIGITO),
    .SINAL    (SINAL),
    .CARREGA_N(CARREGA_N),
    .LIMPA    (LIMPA),
    .VALOR    (VALOR),
    .VALIDO   (VALIDO),
    .ERRO     (ERRO),
    .DEZENA   (DEZENA),
    .UNIDADE  (UNIDADE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nome, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nome, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input logic s);
    DIGITO    = d;
    SINAL     = s;
    CARREGA_N = 1'b0;
    tick(HOLD);
    CARREGA_N = 1'b1;
    tick(HOLD);
  endtask

  // Reference model: a press is a released sample followed by a pressed sample (both taken
  // after reset); it is acted on two edges after the pressed sample.
  logic [5:0] m_valor;
  logic       m_valido, m_erro, m_sinal;
  logic [3:0] m_dez, m_uni;
  int         m_fase;      // 0: next press is tens, 1: next press is units, 2: computing
  int         n_amostras;
  logic       h1, h2, h3;  // button samples from 1, 2 and 3 edges ago
  int         mag;
  bit         m_press;
  bit         m_on = 1'b0;

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_valor = '0; m_valido = 0; m_erro = 0; m_sinal = 0; m_dez = '0; m_uni = '0;
      m_fase = 0; n_amostras = 0; h1 = 1; h2 = 1; h3 = 1;
    end else begin
      m_press = (n_amostras >= 3) && h3 && !h2;
      if (LIMPA) begin
        m_valor = '0; m_valido = 0; m_erro = 0; m_dez = '0; m_uni = '0; m_fase = 0;
      end else if (m_fase == 2) begin
        mag = 10 * int'(m_dez) + int'(m_uni);
        if (mag > 31) begin
          m_erro = 1; m_valido = 0;
        end else begin
          m_valor  = m_sinal ? 6'(64 - mag) : 6'(mag);
          m_valido = 1;
        end
        m_fase = 0;
      end else if (m_press) begin
        if (m_fase == 0) begin
          m_dez = DIGITO; m_uni = '0; m_valido = 0;
          m_erro = (DIGITO > 9);
          m_fase = (DIGITO > 9) ? 0 : 1;
        end else begin
          m_uni = DIGITO; m_sinal = SINAL;
          if (DIGITO > 9) begin
            m_erro = 1; m_fase = 0;
          end else begin
            m_fase = 2;
          end
        end
      end
      h3 = h2; h2 = h1; h1 = CARREGA_N;
      if (n_amostras < 3) n_amostras++;
    end
  end

  always @(negedge CLOCK_50) begin
    if (m_on)
      chk("cycle", {VALOR, VALIDO, ERRO, DEZENA, UNIDADE},
          {m_valor, m_valido, m_erro, m_dez, m_uni});
  end

  initial begin
    RESET_N = 1'b0; CARREGA_N = 1'b1; LIMPA = 1'b0; DIGITO = '0; SINAL = 1'b0;
    tick(3);
    RESET_N = 1'b1;
`ifndef DEBOUNCE_EN
    m_on = 1'b1;
`endif
    tick(5);
    chk("rst_outputs", {VALOR, VALIDO, ERRO, DEZENA, UNIDADE}, 16'd0);

    // 2 then 3, positive: watch capture and result edges
    press(4'd2, 1'b0);
    DIGITO = 4'd3; SINAL = 1'b0; CARREGA_N = 1'b0;
    tick(CAP - 1);
    chk("uni_before_capture", 16'(UNIDADE), 16'd0);
    tick(1);
    chk("uni_at_capture", 16'(UNIDADE), 16'd3);
    chk("valido_in_calcula", 16'(VALIDO), 16'd0);
    tick(1);
    chk("valido_23", 16'(VALIDO), 16'd1);
    chk("valor_23", 16'(VALOR), 16'd23);
    chk("erro_23", 16'(ERRO), 16'd0);
    chk("dezena_23", 16'(DEZENA), 16'd2);
    CARREGA_N = 1'b1;
    tick(HOLD);

    press(4'd1, 1'b0);
    press(4'd5, 1'b1);
    chk("valor_m15", 16'(VALOR), 16'h31);
    chk("valido_m15", 16'(VALIDO), 16'd1);
    press(4'd0, 1'b0);
    chk("new_entry_valido", 16'(VALIDO), 16'd0);
    chk("new_entry_dezena", 16'(DEZENA), 16'd0);
    chk("new_entry_keeps_valor", 16'(VALOR), 16'h31);
    press(4'd7, 1'b0);  // units of 07
    chk("valor_07", 16'(VALOR), 16'd7);

    press(4'd4, 1'b0);
    press(4'd0, 1'b0);
    chk("erro_40", 16'(ERRO), 16'd1);
    chk("valido_40", 16'(VALIDO), 16'd0);
    chk("valor_kept_40", 16'(VALOR), 16'd7);
    press(4'd0, 1'b0);
    press(4'd0, 1'b1);
    chk("neg_zero", {VALOR, VALIDO, ERRO}, {6'd0, 1'b1, 1'b0});

    // digit > 9 flags ERRO on the capture edge itself
    DIGITO = 4'd12; CARREGA_N = 1'b0;
    tick(CAP - 1);
    chk("erro_before_bad", 16'(ERRO), 16'd0);
    tick(1);
    chk("erro_bad_digit", 16'(ERRO), 16'd1);
    chk("dezena_bad_digit", 16'(DEZENA), 16'd12);
    CARREGA_N = 1'b1;
    tick(HOLD);
    press(4'd3, 1'b0);
    chk("erro_cleared", {ERRO, VALIDO, DEZENA}, {1'b0, 1'b0, 4'd3});
    press(4'd1, 1'b1);
    chk("valor_m31", 16'(VALOR), 16'h21);

    // LIMPA coincident with the capture edge wins and the press is lost
    DIGITO = 4'd9; CARREGA_N = 1'b0;
    tick(CAP - 1);
    LIMPA = 1'b1;
    tick(1);
    LIMPA = 1'b0;
    chk("limpa_all_zero", {VALOR, VALIDO, ERRO, DEZENA, UNIDADE}, 16'd0);
    CARREGA_N = 1'b1;
    tick(HOLD);
    press(4'd2, 1'b0);
    press(4'd5, 1'b0);
    chk("after_limpa_25", {VALOR, DEZENA}, {6'd25, 4'd2});

    // asynchronous reset mid-entry, button held across it
    press(4'd6, 1'b0);
    DIGITO = 4'd5; CARREGA_N = 1'b0;
    tick(2);
    #2 RESET_N = 1'b0;
    #1 chk("async_reset", {VALOR, VALIDO, ERRO, DEZENA, UNIDADE}, 16'd0);
    tick(2);
    RESET_N = 1'b1;
    tick(CAP + 8);
    chk("held_no_pulse", 16'(DEZENA), 16'd0);
    CARREGA_N = 1'b1;
    tick(HOLD);
    press(4'd5, 1'b0);
    chk("press_after_release", 16'(DEZENA), 16'd5);

`ifdef DEBOUNCE_EN
    DIGITO = 4'd8; CARREGA_N = 1'b0;
    tick(10);
    CARREGA_N = 1'b1;
    tick(HOLD);
    chk("glitch_ignored", 16'(DEZENA), 16'd5);
    DIGITO = 4'd2; CARREGA_N = 1'b0;
    tick(18);
    chk("deb_before_19", 16'(DEZENA), 16'd5);
    tick(1);
    chk("deb_at_19", 16'(DEZENA), 16'd2);
    tick(1);
    DIGITO = 4'd9;
    CARREGA_N = 1'b1; tick(3);
    CARREGA_N = 1'b0; tick(3);
    CARREGA_N = 1'b1; tick(3);
    CARREGA_N = 1'b0; tick(2);
    CARREGA_N = 1'b1;
    tick(HOLD);
    chk("bouncy_release", 16'(DEZENA), 16'd2);
`else
    // random traffic: bouncy button, digits changing every cycle, occasional clear
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) CARREGA_N = ~CARREGA_N;
      if ($urandom_range(0, 1) == 0) DIGITO = 4'($urandom_range(0, 3));
      else if ($urandom_range(0, 7) == 0) DIGITO = 4'($urandom_range(10, 15));
      else DIGITO = 4'($urandom_range(0, 9));
      SINAL = 1'($urandom_range(0, 1));
      LIMPA = ($urandom_range(0, 59) == 0);
      tick(1);
    end
    LIMPA = 1'b0;
    CARREGA_N = 1'b1;
    tick(4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
